// File: rtl/sand_update_engine.sv
// Falling-sand writer: one bottom-up pass per frame_start_i over a 1-bit-per-cell grid,
// reading through a 1-cycle-latency port and writing through a separate write port.
module sand_update_engine #(
   parameter int ACTIVE_COLUMNS = 640,
   parameter int ACTIVE_ROWS    = 480,
   parameter int ADDR_WIDTH     = 19
) (
   input  logic                              clk_i,
   input  logic                              reset_i,
   input  logic                              frame_start_i,
   input  logic                              spawn_req_i,
   input  logic [$clog2(ACTIVE_COLUMNS)-1:0] spawn_x_i,
   input  logic [$clog2(ACTIVE_ROWS)-1:0]    spawn_y_i,
   output logic [ADDR_WIDTH-1:0]             rd_addr_o,
   input  logic                              rd_data_i,
   output logic                              wr_en_o,
   output logic [ADDR_WIDTH-1:0]             wr_addr_o,
   output logic                              wr_data_o,
   output logic                              busy_o,
   output logic                              frame_done_o
);

   localparam int XW = $clog2(ACTIVE_COLUMNS);
   localparam int YW = $clog2(ACTIVE_ROWS);
   localparam logic [XW-1:0] XLAST  = XW'(ACTIVE_COLUMNS - 1);
   localparam logic [YW-1:0] YSTART = YW'(ACTIVE_ROWS - 2);

   typedef enum logic [3:0] {
      IDLE,
      SPAWN,
      RD_SELF,
      CHK_SELF,
      CHK_BELOW,
      CHK_BL,
      CHK_BR,
      WR_CLR,
      WR_DST,
      DONE
   } state_t;

   state_t                state_q, state_d;
   logic [XW-1:0]         x_q, x_d;
   logic [YW-1:0]         y_q, y_d;
   logic [XW-1:0]         dst_x_q, dst_x_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic                  spawn_pend_q;
   logic [XW-1:0]         spawn_x_q;
   logic [YW-1:0]         spawn_y_q;
   logic [YW-1:0]         y_below;
   logic                  spawn_in_range;
   logic                  advance;

   function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [XW-1:0] x,
                                                     input logic [YW-1:0] y);
      return ADDR_WIDTH'(y) * ADDR_WIDTH'(ACTIVE_COLUMNS) + ADDR_WIDTH'(x);
   endfunction

   assign y_below        = y_q + YW'(1);
   assign spawn_in_range = (int'(spawn_x_q) < ACTIVE_COLUMNS) &&
                           (int'(spawn_y_q) < ACTIVE_ROWS);

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q   <= IDLE;
         x_q       <= '0;
         y_q       <= '0;
         dst_x_q   <= '0;
         rd_addr_q <= '0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         dst_x_q   <= dst_x_d;
         rd_addr_q <= rd_addr_d;
      end
   end

   // A new request always wins over the clear in SPAWN so it is not lost.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         spawn_pend_q <= 1'b0;
         spawn_x_q    <= '0;
         spawn_y_q    <= '0;
      end else if (spawn_req_i) begin
         spawn_pend_q <= 1'b1;
         spawn_x_q    <= spawn_x_i;
         spawn_y_q    <= spawn_y_i;
      end else if (state_q == SPAWN) begin
         spawn_pend_q <= 1'b0;
      end
   end

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      dst_x_d   = dst_x_q;
      rd_addr_d = rd_addr_q;
      wr_en_o   = 1'b0;
      wr_addr_o = '0;
      wr_data_o = 1'b0;
      advance   = 1'b0;

      case (state_q)
         IDLE: begin
            if (frame_start_i) begin
               x_d     = '0;
               y_d     = YSTART;
               state_d = (spawn_pend_q || spawn_req_i) ? SPAWN : RD_SELF;
            end
         end
         SPAWN: begin
            if (spawn_in_range) begin
               wr_en_o   = 1'b1;
               wr_addr_o = addr_of(spawn_x_q, spawn_y_q);
               wr_data_o = 1'b1;
            end
            state_d = RD_SELF;
         end
         RD_SELF: begin
            rd_addr_d = addr_of(x_q, y_q);
            state_d   = CHK_SELF;
         end
         CHK_SELF: begin
            if (rd_data_i) begin
               rd_addr_d = addr_of(x_q, y_below);
               state_d   = CHK_BELOW;
            end else begin
               advance = 1'b1;
            end
         end
         CHK_BELOW: begin
            if (!rd_data_i) begin
               dst_x_d = x_q;
               state_d = WR_CLR;
            end else if (x_q != '0) begin
               rd_addr_d = addr_of(x_q - XW'(1), y_below);
               state_d   = CHK_BL;
            end else if (x_q != XLAST) begin
               rd_addr_d = addr_of(x_q + XW'(1), y_below);
               state_d   = CHK_BR;
            end else begin
               advance = 1'b1;
            end
         end
         CHK_BL: begin
            if (!rd_data_i) begin
               dst_x_d = x_q - XW'(1);
               state_d = WR_CLR;
            end else if (x_q != XLAST) begin
               rd_addr_d = addr_of(x_q + XW'(1), y_below);
               state_d   = CHK_BR;
            end else begin
               advance = 1'b1;
            end
         end
         CHK_BR: begin
            if (!rd_data_i) begin
               dst_x_d = x_q + XW'(1);
               state_d = WR_CLR;
            end else begin
               advance = 1'b1;
            end
         end
         WR_CLR: begin
            wr_en_o   = 1'b1;
            wr_addr_o = addr_of(x_q, y_q);
            wr_data_o = 1'b0;
            state_d   = WR_DST;
         end
         WR_DST: begin
            wr_en_o   = 1'b1;
            wr_addr_o = addr_of(dst_x_q, y_below);
            wr_data_o = 1'b1;
            advance   = 1'b1;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Row-major step, moving upward one row after the last column.
      if (advance) begin
         if (x_q == XLAST) begin
            if (y_q == '0) begin
               state_d = DONE;
            end else begin
               x_d     = '0;
               y_d     = y_q - YW'(1);
               state_d = RD_SELF;
            end
         end else begin
            x_d     = x_q + XW'(1);
            state_d = RD_SELF;
         end
      end
   end

   assign rd_addr_o    = rd_addr_d;
   assign busy_o       = (state_q != IDLE);
   assign frame_done_o = (state_q == DONE);

endmodule

// File: tb/tb_sand_update_engine.sv
// Self-checking bench for sand_update_engine on a 4x4 grid, plus a 5x4 instance
// for the out-of-range spawn case; writes are checked against a scoreboard queue.
module tb_sand_update_engine;

   logic       clk_i = 1'b0;
   logic       reset_i = 1'b0;
   logic       frame_start_i = 1'b0;
   logic       spawn_req_i = 1'b0;
   logic [1:0] spawn_x_i = '0;
   logic [1:0] spawn_y_i = '0;
   logic [3:0] rd_addr_o;
   logic       rd_data_i = 1'b0;
   logic       wr_en_o;
   logic [3:0] wr_addr_o;
   logic       wr_data_o;
   logic       busy_o;
   logic       frame_done_o;

   logic       frameStart2 = 1'b0;
   logic       spawnReq2 = 1'b0;
   logic [2:0] spawnX2 = '0;
   logic [1:0] spawnY2 = '0;
   logic [4:0] rdAddr2;
   logic       rdData2 = 1'b0;
   logic       wrEn2;
   logic [4:0] wrAddr2;
   logic       wrData2;
   logic       busy2;
   logic       frameDone2;

   logic [15:0] mem;
   logic [15:0] loadVal = '0;
   logic        loadReq = 1'b0;
   logic [31:0] mem2 = '0;

   logic [4:0] expQ[$];
   int checkCnt = 0;
   int passCnt  = 0;

   sand_update_engine #(.ACTIVE_COLUMNS(4), .ACTIVE_ROWS(4), .ADDR_WIDTH(4)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .frame_start_i(frame_start_i),
      .spawn_req_i(spawn_req_i), .spawn_x_i(spawn_x_i), .spawn_y_i(spawn_y_i),
      .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i), .wr_en_o(wr_en_o),
      .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .busy_o(busy_o),
      .frame_done_o(frame_done_o)
   );

   sand_update_engine #(.ACTIVE_COLUMNS(5), .ACTIVE_ROWS(4), .ADDR_WIDTH(5)) dut5 (
      .clk_i(clk_i), .reset_i(reset_i), .frame_start_i(frameStart2),
      .spawn_req_i(spawnReq2), .spawn_x_i(spawnX2), .spawn_y_i(spawnY2),
      .rd_addr_o(rdAddr2), .rd_data_i(rdData2), .wr_en_o(wrEn2),
      .wr_addr_o(wrAddr2), .wr_data_o(wrData2), .busy_o(busy2),
      .frame_done_o(frameDone2)
   );

   always #5 clk_i = ~clk_i;

   // Register-file models: one-cycle read latency, writes commit at the edge.
   always @(posedge clk_i) begin
      rd_data_i <= mem[rd_addr_o];
      if (loadReq) mem <= loadVal;
      else if (wr_en_o) mem[wr_addr_o] <= wr_data_o;
   end

   always @(posedge clk_i) begin
      rdData2 <= mem2[rdAddr2];
      if (wrEn2) mem2[wrAddr2] <= wrData2;
   end

   // Scoreboard: every write strobe pops the oldest expected {addr,data}.
   always @(negedge clk_i) begin
      if (wr_en_o) begin
         checkCnt++;
         if (expQ.size() == 0) begin
            $display("[TB] FAIL write_unexpected: got addr=%0d data=%0d, expected no write",
                     wr_addr_o, wr_data_o);
         end else begin
            logic [4:0] e;
            e = expQ.pop_front();
            if ({wr_addr_o, wr_data_o} !== e)
               $display("[TB] FAIL write_order: got addr=%0d data=%0d, expected addr=%0d data=%0d",
                        wr_addr_o, wr_data_o, e[4:1], e[0]);
            else passCnt++;
         end
      end
   end

   task automatic push_wr(input int addr, input logic data);
      expQ.push_back({4'(addr), data});
   endtask

   task automatic load_grid(input logic [15:0] val);
      @(posedge clk_i); #1;
      loadVal = val;
      loadReq = 1'b1;
      @(posedge clk_i); #1;
      loadReq = 1'b0;
   endtask

   task automatic check_grid(input string name, input logic [15:0] expGrid);
      checkCnt++;
      if (mem !== expGrid)
         $display("[TB] FAIL %s_grid: got %b, expected %b", name, mem, expGrid);
      else passCnt++;
   endtask

   // Runs one pass on the 4x4 instance, optionally pulsing frame_start_i or
   // spawn_req_i again at a given busy-cycle index.
   task automatic run_pass(input string name, input int expCycles, input int expWrites,
                           input int extraStartAt, input int spawnAt,
                           input logic [1:0] sx, input logic [1:0] sy);
      int busyCnt = 0;
      int wrCnt = 0;
      int cyc = 0;
      bit seenDone = 1'b0;
      @(posedge clk_i); #1;
      frame_start_i = 1'b1;
      @(posedge clk_i); #1;
      frame_start_i = 1'b0;
      while (!seenDone && cyc < 300) begin
         @(negedge clk_i);
         cyc++;
         if (busy_o) busyCnt++;
         if (wr_en_o) wrCnt++;
         if (frame_done_o) seenDone = 1'b1;
         frame_start_i = (cyc == extraStartAt);
         spawn_req_i   = (cyc == spawnAt);
         if (cyc == spawnAt) begin
            spawn_x_i = sx;
            spawn_y_i = sy;
         end
      end
      @(negedge clk_i);
      frame_start_i = 1'b0;
      spawn_req_i   = 1'b0;
      checkCnt++;
      if (!seenDone) $display("[TB] FAIL %s_timeout: no frame_done_o within %0d cycles", name, cyc);
      else passCnt++;
      checkCnt++;
      if (busyCnt != expCycles)
         $display("[TB] FAIL %s_cycles: got %0d busy cycles, expected %0d", name, busyCnt, expCycles);
      else passCnt++;
      checkCnt++;
      if (wrCnt != expWrites)
         $display("[TB] FAIL %s_writes: got %0d, expected %0d", name, wrCnt, expWrites);
      else passCnt++;
      checkCnt++;
      if ({busy_o, frame_done_o} !== 2'b00)
         $display("[TB] FAIL %s_idle_after: got busy=%b done=%b, expected 0 0", name, busy_o, frame_done_o);
      else passCnt++;
      checkCnt++;
      if (expQ.size() != 0) begin
         $display("[TB] FAIL %s_pending_writes: got %0d left, expected 0", name, expQ.size());
         expQ.delete();
      end else passCnt++;
   endtask

   task automatic test_reset;
      reset_i = 1'b0;
      #12;
      checkCnt++;
      if ({busy_o, frame_done_o, wr_en_o, wr_data_o} !== 4'b0000)
         $display("[TB] FAIL reset_flags: got %b, expected 0000", {busy_o, frame_done_o, wr_en_o, wr_data_o});
      else passCnt++;
      checkCnt++;
      if ({rd_addr_o, wr_addr_o} !== 8'h00)
         $display("[TB] FAIL reset_addrs: got rd=%0d wr=%0d, expected 0 0", rd_addr_o, wr_addr_o);
      else passCnt++;
      @(negedge clk_i);
      reset_i = 1'b1;
   endtask

   task automatic test_empty_grid;
      load_grid(16'h0000);
      run_pass("empty", 25, 0, -1, -1, 2'd0, 2'd0);
      check_grid("empty", 16'h0000);
   endtask

   task automatic test_single_fall;
      logic [15:0] g;
      load_grid(16'h0002);
      push_wr(1, 1'b0); push_wr(5, 1'b1);
      run_pass("fall1", 28, 2, -1, -1, 2'd0, 2'd0);
      check_grid("fall1", 16'h0020);
      push_wr(5, 1'b0); push_wr(9, 1'b1);
      run_pass("fall2", 28, 2, -1, -1, 2'd0, 2'd0);
      check_grid("fall2", 16'h0200);
      push_wr(9, 1'b0); push_wr(13, 1'b1);
      run_pass("fall3", 28, 2, -1, -1, 2'd0, 2'd0);
      check_grid("fall3", 16'h2000);
      run_pass("fall4", 25, 0, -1, -1, 2'd0, 2'd0);
      g = mem;
      checkCnt++;
      if ($countones(g) != 1)
         $display("[TB] FAIL fall_grain_count: got %0d, expected 1", $countones(g));
      else passCnt++;
   endtask

   task automatic test_left_diag;
      load_grid(16'h4400);
      push_wr(10, 1'b0); push_wr(13, 1'b1);
      run_pass("left", 29, 2, -1, -1, 2'd0, 2'd0);
      check_grid("left", 16'h6000);
   endtask

   task automatic test_right_diag;
      load_grid(16'h1100);
      push_wr(8, 1'b0); push_wr(13, 1'b1);
      run_pass("right", 29, 2, -1, -1, 2'd0, 2'd0);
      check_grid("right", 16'h3000);
   endtask

   task automatic test_blocked;
      load_grid(16'hF200);
      run_pass("blocked", 28, 0, -1, -1, 2'd0, 2'd0);
      check_grid("blocked", 16'hF200);
   endtask

   task automatic test_spawn;
      load_grid(16'h0000);
      run_pass("spawn_busy", 25, 0, -1, 5, 2'd3, 2'd0);
      push_wr(3, 1'b1); push_wr(3, 1'b0); push_wr(7, 1'b1);
      run_pass("spawn_pass", 29, 3, -1, -1, 2'd0, 2'd0);
      check_grid("spawn", 16'h0080);
   endtask

   task automatic test_spawn_out_of_range;
      int busyCnt = 0;
      int wrCnt = 0;
      int cyc = 0;
      bit seenDone = 1'b0;
      @(posedge clk_i); #1;
      frameStart2 = 1'b1;
      spawnReq2   = 1'b1;
      spawnX2     = 3'd6;
      spawnY2     = 2'd0;
      @(posedge clk_i); #1;
      frameStart2 = 1'b0;
      spawnReq2   = 1'b0;
      while (!seenDone && cyc < 300) begin
         @(negedge clk_i);
         cyc++;
         if (busy2) busyCnt++;
         if (wrEn2) wrCnt++;
         if (frameDone2) seenDone = 1'b1;
      end
      checkCnt++;
      if (!seenDone || busyCnt != 32)
         $display("[TB] FAIL drop_cycles: got %0d busy cycles (done=%b), expected 32", busyCnt, seenDone);
      else passCnt++;
      checkCnt++;
      if (wrCnt != 0 || mem2 !== 32'h0)
         $display("[TB] FAIL drop_writes: got %0d writes mem=%h, expected 0 writes", wrCnt, mem2);
      else passCnt++;
   endtask

   task automatic test_reset_mid_pass;
      int cyc = 0;
      load_grid(16'h0002);
      @(posedge clk_i); #1;
      frame_start_i = 1'b1;
      @(posedge clk_i); #1;
      frame_start_i = 1'b0;
      while (cyc < 3) begin
         @(negedge clk_i);
         cyc++;
      end
      checkCnt++;
      if (busy_o !== 1'b1) $display("[TB] FAIL abort_busy_before: got %b, expected 1", busy_o);
      else passCnt++;
      #2 reset_i = 1'b0;
      #1;
      checkCnt++;
      if ({busy_o, frame_done_o, wr_en_o, wr_data_o, rd_addr_o, wr_addr_o} !== 12'h000)
         $display("[TB] FAIL abort_outputs: got busy=%b done=%b we=%b rd=%0d wr=%0d, expected all 0",
                  busy_o, frame_done_o, wr_en_o, rd_addr_o, wr_addr_o);
      else passCnt++;
      @(negedge clk_i);
      @(negedge clk_i);
      reset_i = 1'b1;
      check_grid("abort_kept", 16'h0002);
      push_wr(1, 1'b0); push_wr(5, 1'b1);
      run_pass("after_abort", 28, 2, -1, -1, 2'd0, 2'd0);
      check_grid("after_abort", 16'h0020);
   endtask

   task automatic test_back_to_back;
      int doneCnt = 0;
      load_grid(16'h0000);
      run_pass("ignored_start", 25, 0, 10, -1, 2'd0, 2'd0);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk_i);
         if (frame_done_o || busy_o) doneCnt++;
      end
      checkCnt++;
      if (doneCnt != 0)
         $display("[TB] FAIL ignored_start_extra: got %0d busy/done cycles after pass, expected 0", doneCnt);
      else passCnt++;
   endtask

   initial begin
      test_reset();
      test_empty_grid();
      test_single_fall();
      test_left_diag();
      test_right_diag();
      test_blocked();
      test_spawn();
      test_spawn_out_of_range();
      test_reset_mid_pass();
      test_back_to_back();
      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end

endmodule

// File: doc/sand_update_engine.md
Name: sand_update_engine

Overview:
- Writer side of the game frame buffer: performs one falling-sand simulation pass per frame trigger over a 1-bit-per-cell grid.
- Reads cells through a synchronous read port and writes updated cells through a separate write port.
- The display path independently reads the same memory image.
- Sits between the frame timing logic (which supplies frame_start_i, for example on vsync) and the game RAM (register_file: 1-cycle read latency, write commits at the clock edge).

Parameters:
- ACTIVE_COLUMNS, 640, grid width in cells
- ACTIVE_ROWS, 480, grid height in cells
- ADDR_WIDTH, 19, memory address width; must satisfy 2^ADDR_WIDTH >= ACTIVE_COLUMNS*ACTIVE_ROWS

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  asynchronous, active-low reset
- frame_start_i  in  1  one-cycle pulse requesting a pass
- spawn_req_i  in  1  one-cycle pulse requesting a grain insertion
- spawn_x_i  in  $clog2(ACTIVE_COLUMNS)  spawn column
- spawn_y_i  in  $clog2(ACTIVE_ROWS)  spawn row
- rd_addr_o  out  ADDR_WIDTH  memory read address
- rd_data_i  in  1  read data, valid the cycle after the address is presented
- wr_en_o  out  1  memory write strobe
- wr_addr_o  out  ADDR_WIDTH  write address
- wr_data_o  out  1  write data (1 = sand, 0 = empty)
- busy_o  out  1  pass in progress
- frame_done_o  out  1  one-cycle pulse at end of pass

Behaviour:
- Reset (reset_i=0, asynchronous):
  - State goes to IDLE; spawn-pending flag and all counters clear.
  - All outputs are 0.
  - Reset mid-pass aborts immediately. Memory writes already committed stay as they are; there is no rollback.
- Addressing: addr = y*ACTIVE_COLUMNS + x, zero-extended to ADDR_WIDTH.
- Spawn:
  - spawn_req_i sets a sticky pending flag and latches x/y, in any state; a later request overwrites the latched coordinates.
  - frame_start_i and spawn_req_i in the same IDLE cycle: the spawn is applied in that pass.
- frame_start_i in IDLE starts a pass. While busy, frame_start_i is ignored; it is not queued.
- States and transitions:
  - IDLE → SPAWN if spawn is pending, else → RD_SELF.
  - SPAWN (1 cycle): if x < ACTIVE_COLUMNS and y < ACTIVE_ROWS, write 1 at the spawn address; out-of-range coordinates are dropped silently. Clears the pending flag. → RD_SELF.
  - Scan order:
    - y runs from ACTIVE_ROWS-2 down to 0 (bottom row never moves).
    - Within a row, x runs from 0 up to ACTIVE_COLUMNS-1.
    - Bottom-up order guarantees each grain moves at most one row per pass.
  - RD_SELF: present addr(x,y). → CHK_SELF.
  - CHK_SELF:
    - rd_data_i=0 → advance (next cell's RD_SELF, or DONE after the last cell).
    - rd_data_i=1 → present addr(x,y+1), → CHK_BELOW.
  - CHK_BELOW:
    - rd_data_i=0 → destination is (x,y+1), → WR_CLR.
    - Otherwise, if x>0, present addr(x-1,y+1), → CHK_BL.
    - Otherwise, if x<ACTIVE_COLUMNS-1, present addr(x+1,y+1), → CHK_BR.
    - Otherwise → advance.
  - CHK_BL:
    - rd_data_i=0 → destination is (x-1,y+1), → WR_CLR.
    - Otherwise, if x<ACTIVE_COLUMNS-1, present addr(x+1,y+1), → CHK_BR.
    - Otherwise → advance.
  - CHK_BR: rd_data_i=0 → destination is (x+1,y+1), → WR_CLR; otherwise → advance.
  - Left diagonal is always tried before right (fixed bias).
  - WR_CLR: write 0 at (x,y). → WR_DST.
  - WR_DST: write 1 at the destination. → advance.
  - DONE (1 cycle): frame_done_o=1. → IDLE.
- Write ordering: every write commits before any later read is presented, so no read-after-write hazard reaches the memory.
- Cycle costs:
  - Empty cell: 2 cycles.
  - Straight fall: 5.
  - Left-diagonal move: 6; right-diagonal move: 7 (6 at x=0).
  - Fully blocked grain: 3 to 5.
- busy_o is 1 in every state except IDLE.
- wr_en_o is 1 only in SPAWN (in-range), WR_CLR and WR_DST.
- rd_addr_o holds its last value when no read is issued.

Test Plan:
All scenarios use ACTIVE_COLUMNS=4, ACTIVE_ROWS=4.
1. Empty grid; frame_start_i sampled at edge k → busy_o=1 for cycles k+1..k+25; frame_done_o=1 only in cycle k+25; wr_en_o never asserted.
2. Single grain at (1,0) → after passes 1, 2, 3 it is at (1,1), (1,2), (1,3); pass 4 produces no writes; grid holds exactly one grain throughout.
3. Grains at (2,3) and (2,2) → after one pass, grains at (2,3) and (1,3) (left preferred); writes are 0@addr10, then 1@addr13.
4. Grains at (0,3) and (0,2) → (0,2) moves to (1,3) via the right diagonal.
5. Grain at (1,2), bottom row full → no writes; blocked grain costs 5 cycles.
6. spawn_req_i with (3,0) while busy, then frame_start_i → the next pass writes 1@addr3 in SPAWN, and that grain reaches (3,1) in the same pass.
7. Non-power-of-two variant (ACTIVE_COLUMNS=5) with spawn_x_i=6 → spawn dropped, no write.
8. reset_i low mid-pass → outputs 0 at once; a subsequent frame_start_i runs a normal pass.
9. frame_start_i while busy → ignored; exactly one frame_done_o pulse.
